// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg: shared state encoding, stream markers and default memory depth for the instruction loader.
package instr_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_e;
  localparam logic [7:0] START_MARK = 8'hFE;
  localparam logic [7:0] END_MARK   = 8'hFF;
  localparam int         DEPTH_DEF  = 64;
endpackage

// File: rtl/instr_byte_packer.sv
// instr_byte_packer: packs accepted bytes little-endian into a 32-bit word and pulses word_rdy_o the cycle after the 4th byte.
module instr_byte_packer (
  input  logic        clk_i,
  input  logic        reset_n,
  input  logic        clr_i,
  input  logic        data_i,
  input  logic [7:0]  byte_i,
  output logic [1:0]  byte_idx_o,
  output logic [31:0] word_o,
  output logic        word_rdy_o
);
  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic        rdy_q, rdy_d;
  always_ff @(posedge clk_i or negedge reset_n)
    if (!reset_n) begin
      idx_q  <= '0;
      word_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
      rdy_q  <= rdy_d;
    end
  // Shifting in from the top leaves byte 0 in [7:0] once four bytes have arrived.
  always_comb begin
    idx_d  = clr_i ? 2'd0 : data_i ? idx_q + 2'd1 : idx_q;
    word_d = data_i ? {byte_i, word_q[31:8]} : word_q;
    rdy_d  = data_i && idx_q == 2'd3;
  end
  assign byte_idx_o = idx_q;
  assign word_o     = word_q;
  assign word_rdy_o = rdy_q;
endmodule

// File: rtl/instr_loader.sv
// instr_loader: turns a marker-framed byte stream into instruction-memory writes and holds the CPU in reset until the image is complete.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = 6
) (
  input  logic          clk_i,
  input  logic          reset_n,
  input  logic          valid_i,
  input  logic [7:0]    instr_i,
  output logic          imem_we_o,
  output logic [AW-1:0] imem_addr_o,
  output logic [31:0]   imem_wdata_o,
  output logic [AW:0]   word_count_o,
  output logic          load_done_o,
  output logic          cpu_rst_o,
  output logic          err_o
);
  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   count_q, count_d, count_eff;
  logic          done_q, done_d, err_q, err_d, cpu_rst_q, cpu_rst_d;
  logic          ready_q, acc, is_start, is_end, boundary, full, clr, data, we;
  logic [1:0]    byte_idx;
  instr_byte_packer u_packer (
    .clk_i      (clk_i),
    .reset_n    (reset_n),
    .clr_i      (clr),
    .data_i     (data),
    .byte_i     (instr_i),
    .byte_idx_o (byte_idx),
    .word_o     (imem_wdata_o),
    .word_rdy_o (we)
  );
  // ready_q rises one edge after reset release, so bytes are taken from the second edge on.
  always_ff @(posedge clk_i or negedge reset_n)
    if (!reset_n) begin
      ready_q   <= 1'b0;
      state_q   <= IDLE;
      addr_q    <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      ready_q   <= 1'b1;
      state_q   <= state_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cpu_rst_q <= cpu_rst_d;
    end
  assign acc       = valid_i && ready_q;
  assign is_start  = instr_i == START_MARK;
  assign is_end    = instr_i == END_MARK;
  assign boundary  = byte_idx == 2'd0;
  // A write still in flight counts toward the limit, so a start byte arriving during the strobe sees it.
  assign count_eff = count_q + {{AW{1'b0}}, we};
  assign full      = count_eff == (AW+1)'(DEPTH);
  always_comb begin
    state_d = state_q;
    if (acc && state_q != ERR)
      state_d = (state_q != LOAD) ? (is_start ? LOAD : state_q)
              : (!boundary || is_start) ? LOAD : is_end ? DONE : full ? ERR : LOAD;
  end
  always_comb begin
    clr       = acc && is_start && (state_q == IDLE || state_q == DONE || (state_q == LOAD && boundary));
    data      = acc && state_q == LOAD && (!boundary || (!is_start && !is_end && !full));
    addr_d    = clr ? '0 : we ? addr_q + 1'b1 : addr_q;
    count_d   = clr ? '0 : we ? count_q + 1'b1 : count_q;
    done_d    = state_d == DONE;
    err_d     = state_d == ERR;
    cpu_rst_d = state_d != DONE;
  end
  assign imem_we_o    = we;
  assign imem_addr_o  = addr_q;
  assign word_count_o = count_q;
  assign load_done_o  = done_q;
  assign err_o        = err_q;
  assign cpu_rst_o    = cpu_rst_q;
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed byte streams checked every cycle against a byte-level image model, plus literal expectations.
module tb_instr_loader;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  logic          clk_i, reset_n, valid_i;
  logic [7:0]    instr_i;
  logic          imem_we_o, load_done_o, cpu_rst_o, err_o;
  logic [AW-1:0] imem_addr_o;
  logic [31:0]   imem_wdata_o;
  logic [AW:0]   word_count_o;
  instr_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i        (clk_i),
    .reset_n      (reset_n),
    .valid_i      (valid_i),
    .instr_i      (instr_i),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_wdata_o (imem_wdata_o),
    .word_count_o (word_count_o),
    .load_done_o  (load_done_o),
    .cpu_rst_o    (cpu_rst_o),
    .err_o        (err_o)
  );
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  int checks = 0, passes = 0;
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask
  // Model: the image as a list of completed words; markers only matter between words.
  bit          m_load, m_done, m_err, mon;
  logic [7:0]  m_cur[$];
  int          m_n, wr_cnt, last_addr;
  logic [31:0] last_data;
  int          q_addr[$];
  logic [31:0] q_data[$];
  function automatic void model_reset();
    m_load = 0; m_done = 0; m_err = 0; m_n = 0;
    m_cur.delete(); q_addr.delete(); q_data.delete();
  endfunction
  function automatic void model_byte(logic [7:0] b);
    if (m_err) return;
    if (!m_load) begin
      if (b == 8'hFE) begin m_load = 1; m_done = 0; m_n = 0; m_cur.delete(); end
      return;
    end
    if (m_cur.size() == 0) begin
      if (b == 8'hFE) begin m_n = 0; return; end
      if (b == 8'hFF) begin m_load = 0; m_done = 1; return; end
      if (m_n == DEPTH) begin m_load = 0; m_err = 1; return; end
    end
    m_cur.push_back(b);
    if (m_cur.size() == 4) begin
      q_addr.push_back(m_n % DEPTH);
      q_data.push_back({m_cur[3], m_cur[2], m_cur[1], m_cur[0]});
      m_n++;
      m_cur.delete();
    end
  endfunction
  initial forever begin
    @(negedge clk_i);
    if (mon) begin
      chk("imem_we", imem_we_o, q_data.size() > 0);
      if (imem_we_o) begin
        wr_cnt++;
        last_addr = imem_addr_o;
        last_data = imem_wdata_o;
      end
      if (q_data.size() > 0) begin
        if (imem_we_o) begin
          chk("imem_addr", imem_addr_o, q_addr[0]);
          chk("imem_wdata", imem_wdata_o, q_data[0]);
        end
        void'(q_addr.pop_front());
        void'(q_data.pop_front());
      end
      chk("load_done", load_done_o, m_done);
      chk("err", err_o, m_err);
      chk("cpu_rst", cpu_rst_o, !m_done);
    end
  end
  task automatic send(logic [7:0] b);
    @(negedge clk_i);
    valid_i = 1'b1;
    instr_i = b;
    @(posedge clk_i);
    model_byte(b);
    #1 valid_i = 1'b0;
    instr_i = 8'hFE;
  endtask
  task automatic send_word(logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
  endtask
  task automatic idle(int n);
    repeat (n) @(posedge clk_i);
  endtask
  task automatic do_reset();
    @(negedge clk_i);
    #2 reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_i);
    #2 reset_n = 1'b1;
    idle(2);
  endtask
  task automatic settle_count(string name, int exp_n);
    idle(2);
    @(negedge clk_i);
    chk({name, "_count"}, word_count_o, m_n);
    chk({name, "_count_lit"}, word_count_o, exp_n);
  endtask
  int w0;
  initial begin
    reset_n = 1'b1; valid_i = 1'b0; instr_i = 8'h00; wr_cnt = 0;
    model_reset();
    #2 reset_n = 1'b0;
    mon = 1;
    #20 reset_n = 1'b1;
    idle(2);
    @(negedge clk_i);
    chk("rst_we", imem_we_o, 0);
    chk("rst_done", load_done_o, 0);
    chk("rst_cpu_rst", cpu_rst_o, 1);
    chk("rst_count", word_count_o, 0);
    chk("rst_wdata", imem_wdata_o, 0);
    send(8'h00); send(8'hFF); send(8'h13);
    w0 = wr_cnt;
    send(8'hFE); send_word(32'h00500513); send(8'hFF);
    @(negedge clk_i);
    chk("basic_done", load_done_o, 1);
    chk("basic_wr", wr_cnt - w0, 1);
    chk("basic_data", last_data, 32'h00500513);
    chk("basic_addr", last_addr, 0);
    settle_count("basic", 1);
    send(8'h13);
    w0 = wr_cnt;
    send(8'hFE);
    @(negedge clk_i);
    chk("reload_done_drop", load_done_o, 0);
    send_word(32'h0000006F); send(8'hFF);
    chk("reload_data", last_data, 32'h0000006F);
    chk("reload_addr", last_addr, 0);
    settle_count("reload", 1);
    chk("reload_done", load_done_o, 1);
    send(8'hFE); send(8'h13); send(8'hFF); send(8'h50); send(8'h00); send(8'hFF);
    settle_count("midff", 1);
    chk("midff_data", last_data, 32'h0050FF13);
    w0 = wr_cnt;
    send(8'hFE); send(8'h13); send(8'h05); idle(3); send(8'h50); send(8'h00); idle(3);
    chk("gap_wr", wr_cnt - w0, 1);
    chk("gap_data", last_data, 32'h00500513);
    send(8'hFF);
    send(8'hFE); send(8'hFF);
    settle_count("empty", 0);
    chk("empty_done", load_done_o, 1);
    send(8'hFE); send_word(32'hDEADBEEF); send(8'hFE); send_word(32'h44332211); send(8'hFF);
    settle_count("restart", 1);
    chk("restart_data", last_data, 32'h44332211);
    chk("restart_addr", last_addr, 0);
    send(8'hFE); send(8'h13); send(8'h05);
    do_reset();
    w0 = wr_cnt;
    send(8'hFE); send_word(32'h00100093); send(8'hFF);
    settle_count("rstmid", 1);
    chk("rstmid_wr", wr_cnt - w0, 1);
    chk("rstmid_data", last_data, 32'h00100093);
    chk("rstmid_addr", last_addr, 0);
    w0 = wr_cnt;
    send(8'hFE);
    for (int i = 0; i < DEPTH; i++) send_word(32'h00000013);
    send(8'h13);
    send(8'hFE); send(8'hFF); send(8'h13);
    settle_count("ovf", 64);
    chk("ovf_wr", wr_cnt - w0, 64);
    chk("ovf_last_addr", last_addr, 63);
    chk("ovf_err", err_o, 1);
    chk("ovf_cpu_rst", cpu_rst_o, 1);
    do_reset();
    @(negedge clk_i);
    chk("final_err", err_o, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit words in the downstream instruction memory.
REQ-002 Parameter AW, default 6: word-address width, equal to log2(DEPTH).
REQ-003 clk_i  input  1  the single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 valid_i  input  1  instr_i carries a byte this cycle.
REQ-006 instr_i  input  8  byte stream from the bench or host; markers 8'hFE = start, 8'hFF = end.
REQ-007 imem_we_o  output  1  one-cycle instruction-memory write strobe.
REQ-008 imem_addr_o  output  AW  word write address.
REQ-009 imem_wdata_o  output  32  assembled instruction word.
REQ-010 word_count_o  output  AW+1  number of words written since the last start marker.
REQ-011 load_done_o  output  1  image complete; level signal.
REQ-012 cpu_rst_o  output  1  active-high reset to the CPU core; held high until load_done_o.
REQ-013 err_o  output  1  sticky overflow error.

Function
REQ-014 The FSM shall have exactly four states: IDLE, LOAD, DONE, ERR.
REQ-015 A byte shall be accepted only when valid_i=1; cycles with valid_i=0 shall change no state, counter or output.
REQ-016 Byte lane pointer: 2-bit byte_idx, cleared on entering LOAD, incremented per accepted data byte, wraps 3->0.
REQ-017 IDLE: 8'hFE -> LOAD; every other byte is ignored.
REQ-018 On IDLE->LOAD: word address and word_count_o shall clear to 0.
REQ-019 LOAD, byte_idx=0: 8'hFE -> restart (address and count cleared, stay in LOAD); 8'hFF -> DONE.
REQ-020 LOAD, byte_idx!=0: every byte, including 8'hFE/8'hFF, is data; markers are recognised only at word boundaries.
REQ-021 Packing is little-endian: accepted byte k of a word (k=0..3) lands in bits [8k+7:8k].
REQ-022 The cycle after the 4th byte is accepted: imem_we_o=1 for exactly one cycle, with imem_addr_o = current word address and imem_wdata_o = the packed word.
REQ-023 On that write, address and word_count_o shall increment by 1.
REQ-024 Start byte of word DEPTH+1 (word_count_o=DEPTH, byte_idx=0, not a marker) -> ERR; no write is issued.
REQ-025 Exactly DEPTH words followed by 8'hFF -> DONE; this is legal.
REQ-026 DONE: load_done_o=1 and cpu_rst_o=0, registered, asserted the cycle after the end marker is accepted.
REQ-027 DONE: 8'hFE -> LOAD (reload): load_done_o=0 and cpu_rst_o=1 the next cycle; every other byte is ignored.
REQ-028 ERR: err_o=1 and cpu_rst_o=1; all input is ignored until reset.
REQ-029 End marker with word_count_o=0 -> DONE with an empty image; legal.
REQ-030 A write strobe pending from the 4th byte shall still issue if the next accepted byte is a marker.

Reset
REQ-031 reset_n=0 shall asynchronously force: state=IDLE, byte_idx=0, address=0, word_count_o=0, imem_we_o=0, imem_wdata_o=0, load_done_o=0, err_o=0, cpu_rst_o=1.
REQ-032 Reset asserted mid-word shall discard the partial word; no write shall be issued after reset.
REQ-033 Deassertion shall be used synchronised; the first byte is accepted on the second rising edge after reset_n rises.

Structure
REQ-034 Package instr_loader_pkg shall hold the state enum, START_MARK=8'hFE, END_MARK=8'hFF and the default DEPTH.
REQ-035 One sub-module, instr_byte_packer, shall hold byte_idx, the 32-bit shift/pack register and the word-ready pulse; the FSM, counters and markers stay in instr_loader.

Verification
REQ-036 FE, 13,05,50,00, FF -> one write, addr 0, data 32'h00500513; load_done_o=1 the cycle after FF; word_count_o=1.
REQ-037 FE, 13,FF,50,00, FF -> mid-word FF treated as data: write data 32'h0050FF13, then DONE.
REQ-038 FE, then 64 words of 32'h00000013, then 13 -> 64 writes at addr 0..63, then err_o=1 and cpu_rst_o stays 1.
REQ-039 FE, 13,05 with valid_i low for 3 cycles, 50,00 -> a single write of 32'h00500513 with no spurious strobe.
REQ-040 FE, 13,05, reset_n pulsed low, FE, 93,00,10,00, FF -> only write is addr 0, data 32'h00100093.
REQ-041 After DONE, FE, 6F,00,00,00, FF -> load_done_o drops, write addr 0 data 32'h0000006F, load_done_o reasserts.
